sat_sum_pipe: RTL
=================

// Module: sat_sum_pipe
// PURPOSE
//   Parametrised, pipelined, saturating N-input signed summer for the ANC datapath,
//   e.g. error = primary + anti-noise (+ further correction terms). Each input
//   channel can be added or subtracted. Sits between the filter outputs and the
//   DAC/error path. Carries a valid/ready stream with stall-based backpressure.
//   Reports overflow per beat and in a sticky flag.
// PARAMETERS
//   WIDTH    16  sample width, signed two's complement, for inputs and output
//   NUM_IN   4   number of input channels, legal range 2..16
//   SAT_EN   1   1: clamp the result to the WIDTH range; 0: wrap (keep the low WIDTH bits)
// PORTS
//   clk         in   1               system clock; all logic acts on the rising edge
//   rst         in   1               asynchronous, active-low reset
//   in_data     in   NUM_IN*WIDTH    channel k occupies bits [k*WIDTH +: WIDTH]
//   sub_mask    in   NUM_IN          bit k = 1: channel k is subtracted; sampled with in_data
//   in_valid    in   1               in_data/sub_mask hold a valid beat
//   in_ready    out  1               block can accept a beat this cycle
//   out_data    out  WIDTH           summed result (saturated or wrapped)
//   out_valid   out  1               out_data holds a valid beat
//   out_ready   in   1               downstream accepts out_data this cycle
//   sat_flag    out  1               overflow occurred on the current out_data beat; qualified by out_valid
//   sat_sticky  out  1               set by any delivered overflowed beat; cleared by clr_sticky
//   clr_sticky  in   1               synchronous clear of sat_sticky
// BEHAVIOUR
//   - LEVELS = $clog2(NUM_IN). Internal width IW = WIDTH+LEVELS+1, so the sum
//     is exact and negating -2^(WIDTH-1) cannot overflow.
//   - Stage 0: on accept (in_valid & in_ready), register every channel
//     sign-extended to IW bits, and negated where sub_mask[k] = 1.
//   - Stages 1..LEVELS: adder tree, pairwise adds. An unpaired odd element
//     passes through its stage unchanged.
//   - Last stage: add, then saturate or wrap, then register into out_data and sat_flag.
//   - Latency: a beat accepted on clock edge E appears on out_data with out_valid = 1
//     after edge E+LEVELS. That is LEVELS+1 edges, e.g. 3 for NUM_IN = 4.
//     Throughput: one beat per clock.
//   - Overflow test: sum > 2^(WIDTH-1)-1 or sum < -2^(WIDTH-1).
//     SAT_EN=1: clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1). SAT_EN=0: low WIDTH bits.
//     sat_flag = overflow in both modes.
//   - Flow control, global stall: adv = !out_valid | out_ready; in_ready = adv
//     (combinational from out_ready). When adv = 0, every stage, its valid bit
//     and out_data hold their values. Bubbles are not collapsed.
//   - out_data, sat_flag and out_valid stay stable while out_valid & !out_ready.
//   - sat_sticky: set on an edge where out_valid & out_ready & sat_flag;
//     cleared by clr_sticky. If set and clear occur on the same edge, set wins.
//   - Reset (rst = 0, asynchronous): all stage valid bits = 0, all data registers
//     = 0, out_data = 0, out_valid = 0, sat_flag = 0, sat_sticky = 0. in_ready = 1
//     once rst is released. A reset mid-stream discards all in-flight beats;
//     nothing partial is emitted.
//   - Input data is don't-care when in_valid = 0. Only valid bits advance meaning;
//     there are no X-propagation requirements on data.
// TESTING
//   1. NUM_IN=4, channels {100,200,-50,25}, sub_mask=0, out_ready=1
//      -> out_data=275, sat_flag=0, out_valid 3 edges after accept.
//   2. All channels 32767 -> 32767, sat_flag=1, sat_sticky=1.
//      All channels -32768 -> -32768, sat_flag=1.
//   3. ch0=-32768, others 0, sub_mask=4'b0001 -> 32767, sat_flag=1 (true sum +32768).
//      ch1=1000, sub_mask=4'b0010 -> -1000, sat_flag=0.
//   4. Stream 8 beats with values 1..8 back-to-back; drop out_ready for cycles 3-5
//      -> in_ready low while stalled, all 8 sums delivered in order, none duplicated or lost.
//   5. SAT_EN=0 build: {32767,1,0,0} -> -32768, sat_flag=1.
//      clr_sticky asserted on the same edge as an overflowed beat -> sat_sticky=1.
//   6. Assert rst low mid-stream with 3 beats in flight -> out_valid=0 immediately,
//      sat_sticky=0. First beat after release emerges with the full LEVELS+1 latency.

Source files
------------

// File: rtl/sat_sum_pipe.sv
// sat_sum_pipe: pipelined N-input signed summer with per-channel add/subtract,
// saturating (or wrapping) output, per-beat and sticky overflow reporting.
// Stream protocol: a beat moves across an interface on a rising edge where
// valid & ready are both high; valid may not depend on ready. The whole pipe
// stalls as one (adv = !out_valid | out_ready), and bubbles are kept in place.
module sat_sum_pipe #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SAT_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         sub_mask,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sat_flag,
    output logic                      sat_sticky,
    input  logic                      clr_sticky
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int IW     = WIDTH + LEVELS + 1;
    // Twice as many slots as channels so that pairwise reads (2j, 2j+1) never
    // leave the array; slots past the live operands stay zero and add nothing.
    localparam int SLOTS  = 2 * NUM_IN;

    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    // Level 0 holds the conditioned channels, levels 1..LEVELS-1 the adder tree.
    logic signed [IW-1:0] stg_q [LEVELS][SLOTS];
    logic signed [IW-1:0] stg_d [LEVELS][SLOTS];
    logic [LEVELS-1:0]    vld_q, vld_d;

    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_flag_q, sat_flag_d;
    logic                 sticky_q, sticky_d;

    logic                 adv;
    logic signed [IW-1:0] sum_full;
    logic [LEVELS+1:0]    sum_top;
    logic                 ovf;
    logic [WIDTH-1:0]     result;

    function automatic logic signed [IW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(IW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Final pairwise add; overflow when the bits above the output sign bit
    // are not all copies of it.
    assign sum_full = stg_q[LEVELS-1][0] + stg_q[LEVELS-1][1];
    assign sum_top  = sum_full[IW-1:WIDTH-1];
    assign ovf      = !((&sum_top) || !(|sum_top));

    // Clamp toward the sign of the exact sum, or keep the low bits when wrapping.
    always_comb begin
        result = sum_full[WIDTH-1:0];
        if (SAT_EN != 0 && ovf) begin
            result = sum_full[IW-1] ? MIN_W : MAX_W;
        end
    end

    // Next state of the input stage and the adder tree; everything holds on stall.
    always_comb begin
        stg_d = stg_q;
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    stg_d[0][k] = sub_mask[k] ? -sext(in_data[k*WIDTH +: WIDTH])
                                              :  sext(in_data[k*WIDTH +: WIDTH]);
                end
            end
            for (int l = 1; l < LEVELS; l++) begin
                vld_d[l] = vld_q[l-1];
                for (int j = 0; j < NUM_IN; j++) begin
                    stg_d[l][j] = stg_q[l-1][2*j] + stg_q[l-1][2*j+1];
                end
            end
        end
    end

    // Next state of the output register and the sticky overflow flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_flag_d  = sat_flag_q;
        if (adv) begin
            out_valid_d = vld_q[LEVELS-1];
            out_data_d  = result;
            sat_flag_d  = ovf && vld_q[LEVELS-1];
        end
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        // A delivered overflowed beat overrides a simultaneous clear.
        if (out_valid_q && out_ready && sat_flag_q) begin
            sticky_d = 1'b1;
        end
    end

    // State registers; reset drops every in-flight beat and zeroes all data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    stg_q[l][s] <= '0;
                end
            end
            vld_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            stg_q       <= stg_d;
            vld_q       <= vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_flag_q  <= sat_flag_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign sat_flag   = sat_flag_q;
    assign sat_sticky = sticky_q;

endmodule
